// File: rtl/ipc_msg_queue_if.sv
// Strobe-style register port shared by the sender and receiver sides of ipc_msg_queue.
// The bus wrapper drives the master modport; the queue owns the slave modport.
interface ipc_msg_queue_if;
    logic        write_in;
    logic        read_in;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;

    modport master (output write_in, read_in, addr, wdata, input ready, rdata);
    modport slave  (input write_in, read_in, addr, wdata, output ready, rdata);
endinterface

// File: rtl/ipc_msg_queue.sv
// One-direction inter-hart message queue: sender stages MSG_WORDS words and sends them
// as one message; receiver reads the head message and acks it to pop.
module ipc_msg_queue #(
    parameter int MESSAGE_DEPTH = 4,
    parameter int MSG_WORDS     = 4,
    parameter int SENDER_ID     = 0,
    parameter int RECEIVER_ID   = 1
) (
    input  logic           clk,
    input  logic           resetn,
    ipc_msg_queue_if.slave s_port,
    ipc_msg_queue_if.slave r_port,
    output logic           r_msg_present,
    output logic           s_space_avail
);
    typedef enum logic {IDLE = 1'b0, RESP = 1'b1} port_state_t;

    localparam int         PW       = (MESSAGE_DEPTH > 1) ? $clog2(MESSAGE_DEPTH) : 1;
    localparam int         WIDX     = (MSG_WORDS > 1) ? $clog2(MSG_WORDS) : 1;
    localparam logic [4:0] DEPTH_C  = 5'(MESSAGE_DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(MESSAGE_DEPTH - 1);
    localparam logic [3:0] CTRL_IDX = 4'h8;
    localparam logic [3:0] STAT_IDX = 4'h9;

    port_state_t s_state, s_state_nxt, r_state, r_state_nxt;

    logic [31:0]   staging [MSG_WORDS];
    logic [31:0]   mem     [MESSAGE_DEPTH][MSG_WORDS];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [4:0]    count;
    logic          ovf;

    logic            full, empty;
    logic [3:0]      s_idx, r_idx;
    logic [WIDX-1:0] s_widx, r_widx;
    logic            s_is_word, r_is_word;
    logic            s_wr, r_wr, s_take, r_take;
    logic            send_req, send_ok, send_drop, ack_ok, ovf_clr;
    logic [31:0]     s_rd_val, r_rd_val;
    logic            unused_bits;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign full  = (count == DEPTH_C);
    assign empty = (count == 5'd0);

    assign s_idx     = s_port.addr[5:2];
    assign r_idx     = r_port.addr[5:2];
    assign s_widx    = s_port.addr[2 +: WIDX];
    assign r_widx    = r_port.addr[2 +: WIDX];
    assign s_is_word = (s_idx < 4'(MSG_WORDS));
    assign r_is_word = (r_idx < 4'(MSG_WORDS));

    // Side effects commit only on the IDLE edge of an access, never again in RESP.
    assign s_take = (s_state == IDLE) && (s_port.write_in || s_port.read_in);
    assign r_take = (r_state == IDLE) && (r_port.write_in || r_port.read_in);
    assign s_wr   = (s_state == IDLE) && s_port.write_in;
    assign r_wr   = (r_state == IDLE) && r_port.write_in;

    // Full/empty use the pre-edge count, so a simultaneous ACK never makes room for a SEND.
    assign send_req  = s_wr && (s_idx == CTRL_IDX) && s_port.wdata[0];
    assign send_ok   = send_req && !full;
    assign send_drop = send_req && full;
    assign ovf_clr   = s_wr && (s_idx == STAT_IDX) && s_port.wdata[1];
    assign ack_ok    = r_wr && (r_idx == CTRL_IDX) && r_port.wdata[0] && !empty;

    assign unused_bits = ^{s_port.wdata[31:2], r_port.wdata[31:1],
                           s_port.addr[1:0], r_port.addr[1:0]};

    always_comb begin
        s_rd_val = '0;
        if (s_is_word)
            s_rd_val = staging[s_widx];
        else if (s_idx == STAT_IDX)
            s_rd_val = {8'(SENDER_ID), 11'b0, count, 6'b0, ovf, full};
    end

    always_comb begin
        r_rd_val = '0;
        if (r_is_word && !empty)
            r_rd_val = mem[rd_ptr][r_widx];
        else if (r_idx == STAT_IDX)
            r_rd_val = {8'(RECEIVER_ID), 11'b0, count, 7'b0, !empty};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s_state <= IDLE;
            r_state <= IDLE;
        end else begin
            s_state <= s_state_nxt;
            r_state <= r_state_nxt;
        end
    end

    always_comb begin
        s_state_nxt  = s_state;
        s_port.ready = 1'b0;
        case (s_state)
            IDLE: if (s_port.write_in || s_port.read_in) s_state_nxt = RESP;
            RESP: begin
                s_state_nxt  = IDLE;
                s_port.ready = 1'b1;
            end
            default: s_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        r_state_nxt  = r_state;
        r_port.ready = 1'b0;
        case (r_state)
            IDLE: if (r_port.write_in || r_port.read_in) r_state_nxt = RESP;
            RESP: begin
                r_state_nxt  = IDLE;
                r_port.ready = 1'b1;
            end
            default: r_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s_port.rdata <= '0;
            r_port.rdata <= '0;
        end else begin
            if (s_take) s_port.rdata <= s_port.read_in ? s_rd_val : '0;
            if (r_take) r_port.rdata <= r_port.read_in ? r_rd_val : '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int w = 0; w < MSG_WORDS; w++) staging[w] <= '0;
            for (int m = 0; m < MESSAGE_DEPTH; m++)
                for (int w = 0; w < MSG_WORDS; w++) mem[m][w] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (s_wr && s_is_word) staging[s_widx] <= s_port.wdata;
            if (send_ok) begin
                for (int w = 0; w < MSG_WORDS; w++) mem[wr_ptr][w] <= staging[w];
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (ack_ok) rd_ptr <= ptr_inc(rd_ptr);
            count <= count + 5'(send_ok) - 5'(ack_ok);
            if (send_drop)
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;
        end
    end

    assign r_msg_present = !empty;
    assign s_space_avail = !full;
endmodule

// File: tb/tb_ipc_msg_queue.sv
// Directed bench for ipc_msg_queue: reset, single message, fill/overflow, wrap,
// simultaneous SEND/ACK and handshake/reset behaviour with hand-computed expectations.
module tb_ipc_msg_queue;
    logic clk;
    logic resetn;
    int   checks;
    int   errors;

    ipc_msg_queue_if s_if();
    ipc_msg_queue_if r_if();
    logic r_msg_present;
    logic s_space_avail;

    ipc_msg_queue #(
        .MESSAGE_DEPTH(4),
        .MSG_WORDS    (4),
        .SENDER_ID    (0),
        .RECEIVER_ID  (1)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .s_port       (s_if),
        .r_port       (r_if),
        .r_msg_present(r_msg_present),
        .s_space_avail(s_space_avail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One access on one port (rx=1: receiver). Returns the captured read data.
    task automatic xfer(input bit rx, input bit wr, input logic [5:0] a,
                        input logic [31:0] d, output logic [31:0] q);
        int n;
        @(negedge clk);
        if (rx) begin
            r_if.write_in = wr; r_if.read_in = !wr; r_if.addr = a; r_if.wdata = d;
        end else begin
            s_if.write_in = wr; s_if.read_in = !wr; s_if.addr = a; s_if.wdata = d;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(rx ? r_if.ready : s_if.ready) && n < 8);
        q = rx ? r_if.rdata : s_if.rdata;
        checks++;
        if ((rx ? r_if.ready : s_if.ready) !== 1'b1) begin
            errors++;
            $display("FAIL xfer_ready rx=%0d addr=%h: no ready within %0d cycles", rx, a, n);
        end
        r_if.write_in = 1'b0; r_if.read_in = 1'b0;
        s_if.write_in = 1'b0; s_if.read_in = 1'b0;
    endtask

    // Accesses started on both ports in the same cycle.
    task automatic dual(input bit swr, input logic [5:0] sa, input logic [31:0] sd,
                        input bit rwr, input logic [5:0] ra, input logic [31:0] rd,
                        output logic [31:0] sq, output logic [31:0] rq);
        int n;
        @(negedge clk);
        s_if.write_in = swr; s_if.read_in = !swr; s_if.addr = sa; s_if.wdata = sd;
        r_if.write_in = rwr; r_if.read_in = !rwr; r_if.addr = ra; r_if.wdata = rd;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(s_if.ready && r_if.ready) && n < 8);
        sq = s_if.rdata;
        rq = r_if.rdata;
        checks++;
        if (!(s_if.ready === 1'b1 && r_if.ready === 1'b1)) begin
            errors++;
            $display("FAIL dual_ready: s_ready=%b r_ready=%b after %0d cycles", s_if.ready, r_if.ready, n);
        end
        s_if.write_in = 1'b0; s_if.read_in = 1'b0;
        r_if.write_in = 1'b0; r_if.read_in = 1'b0;
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] q;
        apply_reset();
        @(negedge clk);
        checks++;
        if (s_if.ready !== 1'b0 || r_if.ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: s=%b r=%b expected 0 0", s_if.ready, r_if.ready);
        end
        checks++;
        if (r_msg_present !== 1'b0 || s_space_avail !== 1'b1) begin
            errors++;
            $display("FAIL reset_levels: present=%b space=%b expected 0 1", r_msg_present, s_space_avail);
        end
        xfer(0, 0, 6'h24, 0, q);
        checks++;
        if (q !== 32'h0000_0000) begin
            errors++;
            $display("FAIL reset_s_status: got %h expected 00000000", q);
        end
        xfer(1, 0, 6'h24, 0, q);
        checks++;
        if (q !== 32'h0100_0000) begin
            errors++;
            $display("FAIL reset_r_status: got %h expected 01000000", q);
        end
    endtask

    task automatic test_single_msg();
        logic [31:0] q;
        logic [31:0] tags [4];
        tags[0] = 32'h11; tags[1] = 32'h22; tags[2] = 32'h33; tags[3] = 32'h44;
        for (int i = 0; i < 4; i++) xfer(0, 1, 6'(4 * i), tags[i], q);
        checks++;
        if (r_msg_present !== 1'b0) begin
            errors++;
            $display("FAIL single_pre_present: got %b expected 0", r_msg_present);
        end
        xfer(0, 1, 6'h20, 32'h1, q);
        checks++;
        if (r_msg_present !== 1'b1) begin
            errors++;
            $display("FAIL single_present: got %b expected 1", r_msg_present);
        end
        for (int i = 0; i < 4; i++) begin
            xfer(1, 0, 6'(4 * i), 0, q);
            checks++;
            if (q !== tags[i]) begin
                errors++;
                $display("FAIL single_word%0d: got %h expected %h", i, q, tags[i]);
            end
        end
        xfer(1, 0, 6'h24, 0, q);
        checks++;
        if (q !== 32'h0100_0101) begin
            errors++;
            $display("FAIL single_r_status: got %h expected 01000101", q);
        end
        xfer(1, 0, 6'h10, 0, q);
        checks++;
        if (q !== 32'h0) begin
            errors++;
            $display("FAIL single_unmapped: got %h expected 0", q);
        end
        xfer(1, 1, 6'h20, 32'h1, q);
        checks++;
        if (r_msg_present !== 1'b0) begin
            errors++;
            $display("FAIL single_ack_present: got %b expected 0", r_msg_present);
        end
        xfer(1, 0, 6'h00, 0, q);
        checks++;
        if (q !== 32'h0) begin
            errors++;
            $display("FAIL single_empty_read: got %h expected 0", q);
        end
    endtask

    task automatic test_fill_overflow();
        logic [31:0] q;
        for (int t = 1; t <= 5; t++) begin
            xfer(0, 1, 6'h00, 32'hA0 + 32'(t), q);
            xfer(0, 1, 6'h20, 32'h1, q);
            if (t == 4) begin
                checks++;
                if (s_space_avail !== 1'b0) begin
                    errors++;
                    $display("FAIL fill_space: got %b expected 0", s_space_avail);
                end
            end
        end
        xfer(0, 0, 6'h24, 0, q);
        checks++;
        if (q !== 32'h0000_0403) begin
            errors++;
            $display("FAIL fill_status: got %h expected 00000403", q);
        end
        for (int t = 1; t <= 4; t++) begin
            xfer(1, 0, 6'h00, 0, q);
            checks++;
            if (q !== 32'hA0 + 32'(t)) begin
                errors++;
                $display("FAIL fill_pop%0d: got %h expected %h", t, q, 32'hA0 + 32'(t));
            end
            xfer(1, 1, 6'h20, 32'h1, q);
        end
        xfer(0, 0, 6'h24, 0, q);
        checks++;
        if (q !== 32'h0000_0002) begin
            errors++;
            $display("FAIL fill_ovf_sticky: got %h expected 00000002", q);
        end
        xfer(0, 1, 6'h24, 32'h2, q);
        xfer(0, 0, 6'h24, 0, q);
        checks++;
        if (q !== 32'h0) begin
            errors++;
            $display("FAIL fill_ovf_clear: got %h expected 00000000", q);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] q;
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 3; k++) begin
                xfer(0, 1, 6'h00, 32'h100 + 32'(16 * r + k), q);
                xfer(0, 1, 6'h20, 32'h1, q);
            end
            for (int k = 0; k < 3; k++) begin
                xfer(1, 0, 6'h00, 0, q);
                checks++;
                if (q !== 32'h100 + 32'(16 * r + k)) begin
                    errors++;
                    $display("FAIL wrap_r%0d_k%0d: got %h expected %h", r, k, q, 32'h100 + 32'(16 * r + k));
                end
                xfer(1, 1, 6'h20, 32'h1, q);
            end
            xfer(1, 0, 6'h24, 0, q);
            checks++;
            if (q !== 32'h0100_0000) begin
                errors++;
                $display("FAIL wrap_r%0d_count: got %h expected 01000000", r, q);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [31:0] q, sq, rq;
        // SEND while receiver reads the empty head: read sees the pre-SEND state.
        xfer(0, 1, 6'h00, 32'hD1, q);
        dual(1, 6'h20, 32'h1, 0, 6'h00, 0, sq, rq);
        checks++;
        if (rq !== 32'h0) begin
            errors++;
            $display("FAIL simul_presend_read: got %h expected 0", rq);
        end
        xfer(1, 0, 6'h00, 0, q);
        checks++;
        if (q !== 32'hD1) begin
            errors++;
            $display("FAIL simul_postsend_read: got %h expected 000000d1", q);
        end
        xfer(0, 1, 6'h00, 32'hD2, q);
        xfer(0, 1, 6'h20, 32'h1, q);
        xfer(0, 1, 6'h00, 32'hD3, q);
        dual(1, 6'h20, 32'h1, 1, 6'h20, 32'h1, sq, rq);
        xfer(0, 0, 6'h24, 0, q);
        checks++;
        if (q !== 32'h0000_0200) begin
            errors++;
            $display("FAIL simul_cnt2_status: got %h expected 00000200", q);
        end
        xfer(1, 0, 6'h00, 0, q);
        checks++;
        if (q !== 32'hD2) begin
            errors++;
            $display("FAIL simul_cnt2_head: got %h expected 000000d2", q);
        end
        xfer(0, 1, 6'h00, 32'hD4, q);
        xfer(0, 1, 6'h20, 32'h1, q);
        xfer(0, 1, 6'h00, 32'hD5, q);
        xfer(0, 1, 6'h20, 32'h1, q);
        xfer(0, 1, 6'h00, 32'hD6, q);
        dual(1, 6'h20, 32'h1, 1, 6'h20, 32'h1, sq, rq);
        xfer(0, 0, 6'h24, 0, q);
        checks++;
        if (q !== 32'h0000_0302) begin
            errors++;
            $display("FAIL simul_full_status: got %h expected 00000302", q);
        end
        for (int k = 3; k <= 5; k++) begin
            xfer(1, 0, 6'h00, 0, q);
            checks++;
            if (q !== 32'hD0 + 32'(k)) begin
                errors++;
                $display("FAIL simul_drain%0d: got %h expected %h", k, q, 32'hD0 + 32'(k));
            end
            xfer(1, 1, 6'h20, 32'h1, q);
        end
        xfer(0, 1, 6'h24, 32'h2, q);
        // ACK on an empty queue alongside a SEND: ACK ignored, SEND kept.
        xfer(0, 1, 6'h00, 32'hD7, q);
        dual(1, 6'h20, 32'h1, 1, 6'h20, 32'h1, sq, rq);
        xfer(0, 0, 6'h24, 0, q);
        checks++;
        if (q !== 32'h0000_0100) begin
            errors++;
            $display("FAIL simul_empty_status: got %h expected 00000100", q);
        end
        xfer(1, 0, 6'h00, 0, q);
        checks++;
        if (q !== 32'hD7) begin
            errors++;
            $display("FAIL simul_empty_head: got %h expected 000000d7", q);
        end
        xfer(1, 1, 6'h20, 32'h1, q);
        checks++;
        if (r_msg_present !== 1'b0) begin
            errors++;
            $display("FAIL simul_final_present: got %b expected 0", r_msg_present);
        end
    endtask

    task automatic test_handshake_reset();
        logic [31:0] q;
        @(negedge clk);
        s_if.read_in = 1'b1; s_if.addr = 6'h24;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (s_if.ready !== ((c % 2) == 0)) begin
                errors++;
                $display("FAIL hs_ready_c%0d: got %b expected %b", c, s_if.ready, (c % 2) == 0);
            end
        end
        s_if.read_in = 1'b0;
        xfer(0, 1, 6'h00, 32'hE1, q);
        xfer(0, 1, 6'h20, 32'h1, q);
        @(negedge clk);
        r_if.read_in = 1'b1; r_if.addr = 6'h00;
        @(negedge clk);
        checks++;
        if (r_if.ready !== 1'b1) begin
            errors++;
            $display("FAIL hs_resp_ready: got %b expected 1", r_if.ready);
        end
        resetn = 1'b0;
        #1;
        checks++;
        if (r_if.ready !== 1'b0 || r_msg_present !== 1'b0 || s_space_avail !== 1'b1) begin
            errors++;
            $display("FAIL hs_async_reset: ready=%b present=%b space=%b expected 0 0 1",
                     r_if.ready, r_msg_present, s_space_avail);
        end
        r_if.read_in = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        xfer(0, 0, 6'h24, 0, q);
        checks++;
        if (q !== 32'h0) begin
            errors++;
            $display("FAIL hs_post_status: got %h expected 0", q);
        end
        xfer(0, 0, 6'h00, 0, q);
        checks++;
        if (q !== 32'h0) begin
            errors++;
            $display("FAIL hs_post_staging: got %h expected 0", q);
        end
        xfer(1, 0, 6'h00, 0, q);
        checks++;
        if (q !== 32'h0) begin
            errors++;
            $display("FAIL hs_post_head: got %h expected 0", q);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        resetn = 1'b0;
        s_if.write_in = 1'b0; s_if.read_in = 1'b0; s_if.addr = '0; s_if.wdata = '0;
        r_if.write_in = 1'b0; r_if.read_in = 1'b0; r_if.addr = '0; r_if.wdata = '0;
        test_reset();
        test_single_msg();
        test_fill_overflow();
        test_wrap();
        test_simultaneous();
        test_handshake_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
